// File: rtl/avg_ser_pkg.sv
// Shared types and constants for the averaged-sample serializer.
// Build with AVG_SER_PARITY_EN defined to append an even parity bit.
package avg_ser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int BIT_CNT_W = 4;
   localparam int SAMPLE_W  = 6;

`ifdef AVG_SER_PARITY_EN
   localparam bit PARITY_EN  = 1'b1;
   localparam int FRAME_BITS = SAMPLE_W + 3;
`else
   localparam bit PARITY_EN  = 1'b0;
   localparam int FRAME_BITS = SAMPLE_W + 2;
`endif

   localparam int X_LSB = 0;
   localparam int Y_LSB = 2;
   localparam int T_LSB = 4;

endpackage

// File: rtl/avg_ser_fifo.sv
// Word FIFO between the averager and the serial framer.
// Registered full flag; depth must be a power of two.
module avg_ser_fifo #(
   parameter int W     = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_nxt;
   logic          push_ok;
   logic          pop_ok;

   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)
         count_nxt = count + CW'(1);
      else if (pop_ok && !push_ok)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= wdata;
   end

   // Reset input is active-high despite its name.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

endmodule

// File: rtl/avg_frame_serializer.sv
// Buffers packed {t,y,x} averages and sends each as a UART-style frame.
// AVG_SER_PARITY_EN adds an even parity bit after the data bits.
module avg_frame_serializer
   import avg_ser_pkg::*;
#(
   parameter int DATA_W       = 6,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   input  logic [DATA_W-1:0]               in_data,
   output logic                            in_ready,
   output logic                            tx_out,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic                            overflow,
   input  logic                            clr_ovf
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);

   state_t                 state;
   logic [BAUD_W-1:0]      baud;
   logic [BIT_CNT_W-1:0]   bit_idx;
   logic [DATA_W-1:0]      shift;
   logic                   par;
   logic [DATA_W-1:0]      head;
   logic                   full;
   logic                   empty;
   logic                   pop;
   logic                   drop;
   logic                   baud_end;

   assign in_ready = ~full;
   assign drop     = in_valid & full;
   assign pop      = (state == IDLE) & ~empty;
   assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));

   avg_ser_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state    <= IDLE;
         baud     <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par      <= 1'b0;
         tx_out   <= 1'b1;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;

         if (state != IDLE)
            baud <= baud_end ? '0 : baud + BAUD_W'(1);

         unique case (state)
            IDLE: begin
               if (!empty) begin
                  state  <= START;
                  shift  <= head;
                  par    <= ^head;
                  tx_out <= 1'b0;
                  baud   <= '0;
                  busy   <= 1'b1;
               end
            end
            START: begin
               if (baud_end) begin
                  state   <= DATA;
                  tx_out  <= shift[0];
                  shift   <= shift >> 1;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (baud_end) begin
                  if (bit_idx == BIT_CNT_W'(DATA_W - 1)) begin
                     if (PARITY_EN) begin
                        state  <= PARITY;
                        tx_out <= par;
                     end else begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                     end
                  end else begin
                     tx_out  <= shift[0];
                     shift   <= shift >> 1;
                     bit_idx <= bit_idx + BIT_CNT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (baud_end) begin
                  state  <= STOP;
                  tx_out <= 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_avg_frame_serializer.sv
// Self-checking bench for avg_frame_serializer against a frame-level model.
// Honours AVG_SER_PARITY_EN for the expected frame layout.
module tb_avg_frame_serializer;

   localparam int DW    = 6;
   localparam int DEPTH = 4;
   localparam int CPB   = 4;
`ifdef AVG_SER_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FB   = DW + 2 + P;
   localparam int FLEN = FB * CPB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          clr_ovf = 1'b0;
   logic          in_ready;
   logic          tx_out;
   logic          busy;
   logic [2:0]    fifo_count;
   logic          overflow;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] q[$];
   bit            mbusy;
   int            mt;
   logic          mbits[16];
   bit            movf;

   always #5 clk = ~clk;

   avg_frame_serializer #(
      .DATA_W       (DW),
      .FIFO_DEPTH   (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .tx_out     (tx_out),
      .busy       (busy),
      .fifo_count (fifo_count),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int exp_tx();
      return mbusy ? int'(mbits[mt / CPB]) : 1;
   endfunction

   task automatic check_all();
      chk("tx_out", int'(tx_out), exp_tx());
      chk("busy", int'(busy), int'(mbusy));
      chk("fifo_count", int'(fifo_count), q.size());
      chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
      chk("overflow", int'(overflow), int'(movf));
   endtask

   task automatic model_reset();
      q.delete();
      mbusy = 0;
      mt = 0;
      movf = 0;
   endtask

   // One clock edge of the reference: frame timeline plus word queue.
   task automatic model_edge(input logic v, input logic [DW-1:0] d,
                             input logic c);
      bit            room;
      logic [DW-1:0] w;
      room = (q.size() != DEPTH);
      if (mbusy) begin
         mt++;
         if (mt == FLEN)
            mbusy = 0;
      end else if (q.size() != 0) begin
         w = q.pop_front();
         mbits[0] = 1'b0;
         for (int i = 0; i < DW; i++)
            mbits[1 + i] = w[i];
         if (P == 1)
            mbits[DW + 1] = ^w;
         mbits[FB - 1] = 1'b1;
         mbusy = 1;
         mt = 0;
      end
      if (v && room)
         q.push_back(d);
      if (v && !room)
         movf = 1;
      else if (c)
         movf = 0;
   endtask

   task automatic step(input logic v, input logic [DW-1:0] d,
                       input logic c);
      in_valid = v;
      in_data  = d;
      clr_ovf  = c;
      @(posedge clk);
      model_edge(v, d, c);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, '0, 1'b0);
   endtask

   initial begin
      int nb;
      logic [DW-1:0] w;

      // Power-on reset
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b0;
      idle(3);

      // Single frame, busy width
      step(1'b1, 6'b101101, 1'b0);
      nb = 0;
      for (int i = 0; i < 60; i++) begin
         step(1'b0, '0, 1'b0);
         if (busy) nb++;
      end
      chk("busy_len", nb, FLEN);

      // Odd-weight word (parity 1 when enabled)
      step(1'b1, 6'b000001, 1'b0);
      idle(FLEN + 4);

      // Six back-to-back words: one dropped
      for (int i = 0; i < 6; i++)
         step(1'b1, DW'($urandom), 1'b0);
      chk("six_ovf", int'(overflow), 1);
      chk("six_count", int'(fifo_count), DEPTH);
      chk("six_ready", int'(in_ready), 0);
      idle(5 * (FLEN + 1) + 4);

      // Clear overflow with no drop
      step(1'b0, '0, 1'b1);
      chk("clr_only", int'(overflow), 0);

      // Clear coincident with a drop: set wins
      for (int i = 0; i < 5; i++)
         step(1'b1, DW'($urandom), 1'b0);
      step(1'b1, DW'($urandom), 1'b1);
      chk("clr_vs_drop", int'(overflow), 1);
      idle(5 * (FLEN + 1) + 4);
      step(1'b0, '0, 1'b1);

      // Async reset in the middle of DATA, two words queued
      for (int i = 0; i < 3; i++)
         step(1'b1, DW'($urandom), 1'b0);
      idle(CPB + 2);
      chk("pre_rst_count", int'(fifo_count), 2);
      chk("pre_rst_busy", int'(busy), 1);
      #2;
      rst_n = 1'b1;
      #1;
      model_reset();
      chk("rst_tx", int'(tx_out), 1);
      chk("rst_count", int'(fifo_count), 0);
      chk("rst_busy", int'(busy), 0);
      check_all();
      @(negedge clk);
      rst_n = 1'b0;
      idle(FLEN + 4);

      // Push on the pop edge with two words queued
      for (int i = 0; i < 3; i++)
         step(1'b1, DW'($urandom), 1'b0);
      for (int k = 0; k < 100 && mbusy; k++)
         idle(1);
      chk("pp_pre_count", int'(fifo_count), 2);
      w = DW'($urandom);
      step(1'b1, w, 1'b0);
      chk("pp_count", int'(fifo_count), 2);
      idle(3 * (FLEN + 1) + 4);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, DW'($urandom),
              $urandom_range(0, 15) == 0);
      idle(DEPTH * (FLEN + 1) + 4 + FLEN);
      chk("drained", int'(fifo_count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
